// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_sub_pkg;

  // Operation phases: waiting for operands, walking the digits, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sub_state_e;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// One DIGIT_W-bit slice of the borrow chain: d = x - y - bi, purely combinational.
module digit_subtractor #(
  parameter int DIGIT_W = 2
) (
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               bi,
  output logic [DIGIT_W-1:0] d,
  output logic               bo,
  output logic               bmsb
);

  logic [DIGIT_W:0] full;

  // Extra top bit of the widened difference is the borrow out of this digit.
  always_comb begin
    full = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};
    d    = full[DIGIT_W-1:0];
    bo   = full[DIGIT_W];
    // The top result bit is x ^ y ^ borrow_in at that position, so the
    // borrow into the top bit can be recovered without a second subtractor.
    bmsb = x[DIGIT_W-1] ^ y[DIGIT_W-1] ^ full[DIGIT_W-1];
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin, one DIGIT_W-bit digit per cycle,
// LSB digit first. Optional signed overflow output enabled by SERIAL_SUB_SIGNED_EN.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// in_ready is 1 only in IDLE; out_valid is 1 only in DONE. The producer holds
// a/b/bin while in_valid waits for in_ready; diff/bout(/ovf) stay stable while
// out_valid waits for out_ready. There is no same-cycle return/accept bypass.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DIGIT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output sub_state_e       state_dbg
`ifdef SERIAL_SUB_SIGNED_EN
  ,
  output logic             ovf
`endif
);

  localparam int NUM_DIG = WIDTH / DIGIT_W;
  localparam int CNT_W   = cnt_width(NUM_DIG);

  generate
    if ((WIDTH % DIGIT_W) != 0) begin : g_bad_digit
      $error("serial_subtractor: WIDTH must be a multiple of DIGIT_W");
    end
  endgenerate

  sub_state_e         state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh, b_sh, res_sh, res_next;
  logic               borrow;
  logic               accept, last_dig;
  logic [DIGIT_W-1:0] dig;
  logic               dig_bo;
`ifdef SERIAL_SUB_SIGNED_EN
  logic               dig_bmsb;
`else
  logic               bmsb_unused;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_dbg = state;
  assign accept    = in_valid && in_ready;
  assign last_dig  = (state == CALC) && (cnt == CNT_W'(NUM_DIG - 1));

  // New digit enters at the MSB end so after NUM_DIG shifts it is fully aligned.
  assign res_next  = (res_sh >> DIGIT_W) | (WIDTH'(dig) << (WIDTH - DIGIT_W));

  digit_subtractor #(.DIGIT_W(DIGIT_W)) u_digit (
    .x    (a_sh[DIGIT_W-1:0]),
    .y    (b_sh[DIGIT_W-1:0]),
    .bi   (borrow),
    .d    (dig),
    .bo   (dig_bo),
`ifdef SERIAL_SUB_SIGNED_EN
    .bmsb (dig_bmsb)
`else
    .bmsb (bmsb_unused)
`endif
  );

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state: accept -> walk NUM_DIG digits -> hold until consumed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = CALC;
      CALC:    if (last_dig)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one digit per CALC cycle, publish on the last digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> DIGIT_W;
          b_sh   <= b_sh >> DIGIT_W;
          res_sh <= res_next;
          borrow <= dig_bo;
          cnt    <= cnt + 1'b1;
          if (last_dig) begin
            diff <= res_next;
            bout <= dig_bo;
`ifdef SERIAL_SUB_SIGNED_EN
            ovf  <= dig_bmsb ^ dig_bo;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8, DIGIT_W=2).
// Define SERIAL_SUB_SIGNED_EN to also exercise the ovf output.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int WIDTH   = 8;
  localparam int DIGIT_W = 2;
  localparam int NUM_DIG = WIDTH / DIGIT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;
  sub_state_e       state_dbg;
  logic             ovf_obs;

  serial_subtractor #(.WIDTH(WIDTH), .DIGIT_W(DIGIT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .state_dbg (state_dbg)
`ifdef SERIAL_SUB_SIGNED_EN
    ,
    .ovf       (ovf_obs)
`endif
  );

`ifndef SERIAL_SUB_SIGNED_EN
  assign ovf_obs = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [WIDTH+1:0] exp_q[$];   // {ovf, bout, diff}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge with the DUT in IDLE; returns at the negedge where out_valid is seen.
  task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi,
                       input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
    int n;
    logic [WIDTH+1:0] e;
    exp_q.push_back({eo, eb, ed});
    check("ready_before_issue", in_ready, 1);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    // Operands must only be sampled at the accept edge.
    a = WIDTH'($urandom_range(0, 255));
    b = WIDTH'($urandom_range(0, 255));
    bin = 1'($urandom_range(0, 1));
    check("busy_in_calc", in_ready, 0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", n, NUM_DIG);
    e = exp_q.pop_front();
    check("diff", diff, e[WIDTH-1:0]);
    check("bout", bout, e[WIDTH]);
`ifdef SERIAL_SUB_SIGNED_EN
    check("ovf", ovf_obs, e[WIDTH+1]);
`endif
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_release", out_valid, 0);
    check("ready_after_release", in_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic seen_valid;

    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_diff", diff, 8'h00);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf_obs, 0);
    check("rst_out_valid2", out_valid, 0);
    check("rst_state", state_dbg, IDLE);

    // Basic op and wrap-around cases
    issue(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0); release_result();
    issue(8'h10, 8'h20, 1'b1, 8'hEF, 1'b1, 1'b0); release_result();
    issue(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0); release_result();
    issue(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0); release_result();

    // Backpressure: hold result for 6 cycles while inputs churn
    issue(8'hC3, 8'h41, 1'b0, 8'h82, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      a = WIDTH'($urandom_range(0, 255));
      b = WIDTH'($urandom_range(0, 255));
      in_valid = ~in_valid;
      @(posedge clk);
      @(negedge clk);
      check("bp_diff", diff, 8'h82);
      check("bp_bout", bout, 0);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    release_result();
    check("idle_holds_diff", diff, 8'h82);
    issue(8'h9C, 8'h9D, 1'b0, 8'hFF, 1'b1, 1'b0); release_result();

    // Reset during the second CALC cycle
    a = 8'h77; b = 8'h11; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);          // accept edge
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);          // first digit edge
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) seen_valid = 1'b1;
    end
    check("midrst_no_result", seen_valid, 0);
    check("midrst_diff", diff, 8'h00);
    check("midrst_bout", bout, 0);
    issue(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0); release_result();

`ifdef SERIAL_SUB_SIGNED_EN
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1); release_result();
    issue(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1); release_result();
    issue(8'h05, 8'h03, 1'b1, 8'h01, 1'b0, 1'b0); release_result();
`endif

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle digit-serial subtractor. Computes diff = a - b - bin over WIDTH/DIGIT_W clock cycles, one DIGIT_W-bit digit per cycle, LSB digit first. Produces the borrow-out.
- Arithmetic counterpart of the team's combinational full adder. Used where area matters more than latency.
- Valid/ready handshake on the operand side and on the result side.

Parameters:
- WIDTH, 8: operand and result width in bits.
- DIGIT_W, 2: bits processed per cycle. WIDTH % DIGIT_W must be 0, otherwise elaboration fails via $error.
- NUM_DIG, WIDTH/DIGIT_W: derived localparam, equal to the compute cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend, unsigned.
- b  input  WIDTH  subtrahend, unsigned.
- bin  input  1  borrow-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out, 1 iff a < b + bin.
- ovf  output  1  signed overflow; present only with SERIAL_SUB_SIGNED_EN.

Behaviour:
- States: IDLE, CALC, DONE.
  - in_ready = (state == IDLE).
  - out_valid = (state == DONE).
- Reset, asynchronous while rst_n = 0:
  - state = IDLE, digit counter = 0, internal borrow = 0.
  - diff = 0, bout = 0, ovf = 0, out_valid = 0.
  - in_ready = 1.
  - Reset mid-CALC or mid-DONE aborts the operation immediately. No partial result is ever presented.
- IDLE:
  - On in_valid && in_ready at edge E0: capture a, b into shift registers and bin into the borrow register; counter = 0; go to CALC.
  - a, b and bin are sampled only at E0. Later changes are ignored.
- CALC, each edge:
  - Low digits: d = a_sh[DIGIT_W-1:0] - b_sh[DIGIT_W-1:0] - borrow.
  - Write d into the result register (shift in from the MSB side). New borrow = borrow out of d.
  - Shift a_sh and b_sh right by DIGIT_W. Increment the counter.
  - When the counter reaches NUM_DIG-1 at an edge, that edge processes the last digit and moves to DONE.
- Latency: out_valid rises exactly NUM_DIG cycles after acceptance edge E0 (4 cycles for 8/2).
- DONE:
  - diff, bout and ovf stay stable while out_valid = 1 and out_ready = 0. Backpressure has no limit.
  - On out_valid && out_ready: go to IDLE. in_ready returns 1 the following cycle.
  - No same-cycle accept/return bypass. Minimum issue interval is NUM_DIG + 2 cycles.
- in_valid while not in IDLE: ignored, with no side effects.
- diff and bout update only on entry to DONE; they hold the last result in IDLE.
- Throughout: WIDTH-bit unsigned arithmetic, with wrap-around at 0 and a borrow chain through all digits.

Optional Feature:
- Macro SERIAL_SUB_SIGNED_EN.
- Defined:
  - Adds the ovf output.
  - ovf = borrow into the MSB XOR bout, computed in the last CALC cycle.
  - ovf = 1 iff the signed result of a - b - bin is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - ovf is held and reset exactly like bout.
- Undefined: no ovf port and no related logic.

Decomposition:
- Package serial_sub_pkg holds:
  - state enum sub_state_e {IDLE, CALC, DONE};
  - function clog2-based counter width helper.
- Sub-module digit_subtractor:
  - parameterised DIGIT_W, purely combinational;
  - inputs x, y, bi; outputs d, bo, bmsb (borrow into the top bit, used for ovf).
- Top level holds the FSM, the shift registers and the counter.

Test Plan (WIDTH=8, DIGIT_W=2):
- Assert rst_n = 0, then release. Required: out_valid = 0, diff = 00, bout = 0, in_ready = 1.
- a=5A, b=23, bin=0. Required: diff=37, bout=0; out_valid first high exactly 4 cycles after the accept edge.
- Wrap-around cases, each requiring correct wrap:
  - a=10, b=20, bin=1 → diff=EF, bout=1.
  - a=00, b=00, bin=1 → diff=FF, bout=1.
  - a=FF, b=FF, bin=0 → diff=00, bout=0.
- Hold out_ready=0 for 6 cycles in DONE, toggling a, b and in_valid meanwhile. Required: diff and bout stable, in_ready=0, no new capture. Then raise out_ready: IDLE next cycle, and a following op gives the correct result.
- Drop rst_n for 1 cycle during the 2nd CALC cycle. Required: out_valid never rises for that op, in_ready=1 after release; the next op a=03, b=05, bin=0 gives diff=FE, bout=1.
- With SERIAL_SUB_SIGNED_EN:
  - a=80, b=01, bin=0 → diff=7F, ovf=1.
  - a=7F, b=FF, bin=0 → diff=80, ovf=1.
  - a=05, b=03, bin=1 → diff=01, ovf=0.
